// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the CPU pipeline and the data memory.
interface dmem_responder_if;

    logic        memRead_i;
    logic        memWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output memRead_i, memWrite_i, addr_i, wdata_i,
        input  rdata_o, stall_o, done_o, err_o
    );

    modport slave (
        input  memRead_i, memWrite_i, addr_i, wdata_i,
        output rdata_o, stall_o, done_o, err_o
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, asynchronous read, deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: holds the pipeline via stall_o for LATENCY+1 cycles per
// request, then pulses done_o (with err_o for malformed requests) for one cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int AW      = clog2(DEPTH);
    localparam int IDX_LSB = clog2(WORD_BYTES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic          req;
    logic          access;
    logic          bad_req;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [31:0]   mem_rdata;

    assign req    = bus.memRead_i | bus.memWrite_i;
    assign idx    = addr_q[AW+IDX_LSB-1:IDX_LSB];
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);

    // Judged on the latched request, so input churn during WAIT cannot affect it.
    assign bad_req = (addr_q[IDX_LSB-1:0] != '0)
                   || ((addr_q >> (AW + IDX_LSB)) != 32'd0)
                   || (rd_q & wr_q);
    assign mem_we  = access & wr_q & ~bad_req;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stall_o = ((state_q == IDLE) && req) || (state_q == WAIT);
        bus.done_o  = done_q;
        bus.err_o   = err_q;
        bus.rdata_o = rdata_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    rd_d    = bus.memRead_i;
                    wr_d    = bus.memWrite_i;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done_d = 1'b1;
                    err_d  = bad_req;
                    if (bad_req) begin
                        rdata_d = 32'd0;
                    end else if (rd_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance,
// both DEPTH=32, checked against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2_n, rst1_n;
    logic sel;
    logic t_rd, t_wr;
    logic [31:0] t_addr, t_wdata;

    dmem_responder_if if2 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk_i (clk),
        .rst_i (rst2_n),
        .bus   (if2.slave)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk_i (clk),
        .rst_i (rst1_n),
        .bus   (if1.slave)
    );

    assign if2.memRead_i  = !sel & t_rd;
    assign if2.memWrite_i = !sel & t_wr;
    assign if2.addr_i     = t_addr;
    assign if2.wdata_i    = t_wdata;
    assign if1.memRead_i  = sel & t_rd;
    assign if1.memWrite_i = sel & t_wr;
    assign if1.addr_i     = t_addr;
    assign if1.wdata_i    = t_wdata;

    logic        obs_stall, obs_done, obs_err;
    logic [31:0] obs_rdata;
    assign obs_stall = sel ? if1.stall_o : if2.stall_o;
    assign obs_done  = sel ? if1.done_o  : if2.done_o;
    assign obs_err   = sel ? if1.err_o   : if2.err_o;
    assign obs_rdata = sel ? if1.rdata_o : if2.rdata_o;

    // Reference state per instance: index 0 is LATENCY=2, index 1 is LATENCY=1.
    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] rdata_m [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_bad(input logic rd, input logic wr, input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0) || (rd && wr);
    endfunction

    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
        int          s, lat, stall_cnt, done_cnt, done_at;
        logic [31:0] got_rdata;
        logic        got_err, bad;
        s   = sel ? 1 : 0;
        lat = sel ? 1 : 2;
        @(negedge clk);
        t_rd = rd; t_wr = wr; t_addr = addr; t_wdata = wdata;
        #1;
        check("stall_on_req", 32'(obs_stall), 32'd1);
        stall_cnt = 1; done_cnt = 0; done_at = 0; got_rdata = '0; got_err = 1'b0;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (obs_stall) stall_cnt++;
            if (obs_done) begin
                done_cnt++;
                done_at   = k;
                got_rdata = obs_rdata;
                got_err   = obs_err;
            end
            if (k <= lat) begin
                t_rd = 1'($urandom); t_wr = 1'($urandom);
                t_addr = $urandom; t_wdata = $urandom;
            end else begin
                t_rd = 1'b0; t_wr = 1'b0;
            end
        end
        bad = is_bad(rd, wr, addr);
        if (bad) begin
            rdata_m[s] = 32'd0;
        end else if (rd) begin
            rdata_m[s] = mem_m[s][addr[AW+1:2]];
        end else begin
            mem_m[s][addr[AW+1:2]] = wdata;
        end
        check("stall_cycles", 32'(stall_cnt), 32'(lat + 1));
        check("done_count",   32'(done_cnt),  32'd1);
        check("done_cycle",   32'(done_at),   32'(lat + 1));
        check("err",          32'(got_err),   32'(bad));
        check("rdata",        got_rdata,      rdata_m[s]);
    endtask

    task automatic rand_txn();
        int          c;
        logic        rd, wr;
        logic [31:0] addr;
        c    = $urandom_range(0, 9);
        addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        rd   = (c < 4);
        wr   = !rd;
        if (c == 8) begin
            addr = addr | 32'($urandom_range(1, 3));
        end else if (c == 9) begin
            addr = addr | (32'($urandom_range(1, 32'hFF_FFFF)) << (AW + 2));
        end
        if ($urandom_range(0, 7) == 0) begin
            rd = 1'b1; wr = 1'b1;
        end
        txn(rd, wr, addr, $urandom);
    endtask

    initial begin
        int idx, nd;
        sel = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_addr = '0; t_wdata = '0;
        rst2_n = 1'b0; rst1_n = 1'b0;
        rdata_m[0] = '0; rdata_m[1] = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_rdata", obs_rdata,        32'd0);
            check("rst_done",  32'(obs_done),    32'd0);
            check("rst_err",   32'(obs_err),     32'd0);
            check("rst_stall", 32'(obs_stall),   32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1; rst1_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, 32'(i) << 2, $urandom);
        end
        sel = 1'b0;

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'h10, 32'h0);
        check("plan_rd_10", obs_rdata, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'h12, 32'h0);
        txn(1'b1, 1'b0, 32'h10, 32'h0);
        txn(1'b0, 1'b1, 32'h80, 32'h0000CAFE);
        txn(1'b1, 1'b0, 32'h0,  32'h0);
        txn(1'b1, 1'b1, 32'h4,  32'h00005555);
        txn(1'b1, 1'b0, 32'h4,  32'h0);

        // Reset during the first WAIT cycle of a write must drop the write.
        @(negedge clk);
        t_wr = 1'b1; t_addr = 32'h8; t_wdata = 32'h1234;
        @(negedge clk);
        rst2_n = 1'b0; t_wr = 1'b0; t_addr = '0;
        #1;
        check("mid_rst_stall", 32'(obs_stall), 32'd0);
        check("mid_rst_done",  32'(obs_done),  32'd0);
        check("mid_rst_rdata", obs_rdata,      32'd0);
        rdata_m[0] = '0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        txn(1'b1, 1'b0, 32'h8, 32'h0);

        repeat (40) rand_txn();

        sel = 1'b1;
        repeat (20) rand_txn();

        // Request held high continuously: one access every LATENCY+2 = 3 cycles.
        idx = $urandom_range(0, DEPTH - 1);
        @(negedge clk);
        t_rd = 1'b1; t_wr = 1'b0; t_addr = 32'(idx) << 2;
        nd = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("hold_stall", 32'(obs_stall), 32'((k % 3) != 2));
            check("hold_done",  32'(obs_done),  32'((k % 3) == 2));
            if (obs_done) begin
                nd++;
                check("hold_rdata", obs_rdata, mem_m[1][idx]);
            end
        end
        t_rd = 1'b0;
        rdata_m[1] = mem_m[1][idx];
        check("hold_done_count", 32'(nd), 32'd10);
        repeat (3) @(negedge clk);
        check("hold_idle_stall", 32'(obs_stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
